// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin framebuffer write arbiter with built-in clear engine

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_write_arbiter #(
   parameter int          NUM_REQ      = 3,
   parameter int          ADDR_W       = `DISP_ADDR_WIDTH,
   parameter int          PIX_COUNT    = 76800,
   parameter logic [11:0] CLEAR_COLOUR = 12'h000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_start,
   output logic                      clear_busy,
   output logic                      clear_done,
   output logic                      fb_we,
   output logic [ADDR_W-1:0]         fb_addr,
   output logic [31:0]               fb_wdata
);

   localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);
   localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic [31:0]         fb_wdata_q, fb_wdata_d;
   logic                clear_done_q, clear_done_d;

   int                  scan_idx;
   logic                grant_found;
   logic [PTR_W-1:0]    grant_idx;
   logic                arb_open;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(scan_idx);
         end
      end
   end

   // Ports are open only in ARB, out of reset, and when no clear is being requested
   assign arb_open = reset_n && (state_q == ST_ARB) && !clear_start;

   // One-hot ready toward the selected requester
   always_comb begin
      req_ready = '0;
      if (arb_open && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      clr_cnt_d    = clr_cnt_q;
      fb_we_d      = 1'b0;
      fb_addr_d    = fb_addr_q;
      fb_wdata_d   = fb_wdata_q;
      clear_done_d = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (clear_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (grant_found) begin
               fb_we_d    = 1'b1;
               fb_addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
               fb_wdata_d = req_wdata[int'(grant_idx)*32 +: 32];
               rr_ptr_d   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
            end
         end
         ST_CLEAR: begin
            fb_we_d    = 1'b1;
            fb_addr_d  = clr_cnt_q;
            fb_wdata_d = {20'd0, CLEAR_COLOUR};
            clr_cnt_d  = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d      = ST_ARB;
               clear_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_ARB;
         rr_ptr_q     <= '0;
         clr_cnt_q    <= '0;
         fb_we_q      <= 1'b0;
         fb_addr_q    <= '0;
         fb_wdata_q   <= '0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         clr_cnt_q    <= clr_cnt_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_wdata_q   <= fb_wdata_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign clear_busy = (state_q == ST_CLEAR);
   assign clear_done = clear_done_q;
   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_wdata   = fb_wdata_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - randomized self-checking bench for fb_write_arbiter

module tb_fb_write_arbiter;

   localparam int          N   = 3;
   localparam int          AW  = 17;
   localparam int          PIX = 1200;
   localparam logic [11:0] COL = 12'h3C5;
   localparam int          OW  = 3 + AW + 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*32-1:0]   req_wdata;
   logic [N-1:0]      req_ready;
   logic              clear_start;
   logic              clear_busy;
   logic              clear_done;
   logic              fb_we;
   logic [AW-1:0]     fb_addr;
   logic [31:0]       fb_wdata;

   fb_write_arbiter #(
      .NUM_REQ      (N),
      .ADDR_W       (AW),
      .PIX_COUNT    (PIX),
      .CLEAR_COLOUR (COL)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_wdata    (fb_wdata)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: pointer, clearing flag and next clear address as plain integers
   int            m_ptr;
   bit            m_clr;
   int            m_caddr;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_data;
   logic [N-1:0]  pending;
   logic [N-1:0]  exp_ready, obs_ready;
   logic [OW-1:0] exp_out, obs_out;

   task automatic model_reset();
      m_ptr   = 0;
      m_clr   = 0;
      m_caddr = 0;
      m_addr  = '0;
      m_data  = '0;
      pending = '0;
   endtask

   task automatic model_step(input logic [N-1:0] v, input logic cs);
      bit we   = 0;
      bit done = 0;
      int g    = -1;
      exp_ready = '0;
      if (m_clr) begin
         we      = 1;
         m_addr  = AW'(m_caddr);
         m_data  = {20'd0, COL};
         done    = (m_caddr == PIX - 1);
         m_caddr = m_caddr + 1;
         if (done) m_clr = 0;
      end else if (cs) begin
         m_clr   = 1;
         m_caddr = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
         end
         if (g >= 0) begin
            exp_ready[g] = 1'b1;
            we           = 1;
            m_addr       = req_addr[g*AW +: AW];
            m_data       = req_wdata[g*32 +: 32];
            m_ptr        = (g + 1) % N;
         end
      end
      exp_out = {we, m_addr, m_data, m_clr, done};
   endtask

   // Drive one cycle (entered just after a rising edge), sample ready before the edge and outputs after it
   task automatic do_cycle(input logic [N-1:0] v, input logic cs, input bit rnd);
      for (int i = 0; i < N; i++) begin
         if (rnd && !pending[i]) begin
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_wdata[i*32 +: 32] = $urandom;
         end
      end
      req_valid   = v;
      clear_start = cs;
      model_step(v, cs);
      #1;
      obs_ready = req_ready;
      @(posedge clk);
      #1;
      obs_out = {fb_we, fb_addr, fb_wdata, clear_busy, clear_done};
      pending = v & ~exp_ready;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      req_valid   = '1;
      clear_start = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=%b", req_ready, {N{1'b0}});
      end
      obs_out = {fb_we, fb_addr, fb_wdata, clear_busy, clear_done};
      checks++;
      if (obs_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", obs_out);
      end
      reset_n   = 1'b1;
      req_valid = '0;
      model_reset();
   endtask

   task automatic test_all_three();
      for (int c = 0; c < 6; c++) begin
         do_cycle(3'b111, 1'b0, 1);
         checks++;
         if (obs_ready !== exp_ready || obs_ready !== N'(1 << (c % 3))) begin
            failures++;
            $display("FAIL all_three_grant c=%0d got=%b exp=%b", c, obs_ready, exp_ready);
         end
         checks++;
         if (obs_out !== exp_out || obs_out[OW-1] !== 1'b1) begin
            failures++;
            $display("FAIL all_three_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
      end
      do_cycle(3'b000, 1'b0, 1);
      checks++;
      if (obs_out !== exp_out || obs_out[OW-1] !== 1'b0) begin
         failures++;
         $display("FAIL all_three_idle got=%h exp=%h", obs_out, exp_out);
      end
   endtask

   task automatic test_single();
      req_addr[1*AW +: AW]  = 17'h00010;
      req_wdata[1*32 +: 32] = 32'h00000ABC;
      do_cycle(3'b010, 1'b0, 0);
      checks++;
      if (obs_ready !== exp_ready || obs_ready !== 3'b010) begin
         failures++;
         $display("FAIL single_ready got=%b exp=%b", obs_ready, 3'b010);
      end
      checks++;
      if (obs_out !== exp_out || obs_out !== {1'b1, 17'h00010, 32'h00000ABC, 2'b00}) begin
         failures++;
         $display("FAIL single_write got=%h exp=%h", obs_out, exp_out);
      end
      do_cycle(3'b000, 1'b0, 1);
      checks++;
      if (obs_out !== exp_out || obs_out[OW-1] !== 1'b0) begin
         failures++;
         $display("FAIL single_after got=%h exp=%h", obs_out, exp_out);
      end
   endtask

   task automatic test_skip();
      logic [N-1:0] order [3];
      order[0] = 3'b100;
      order[1] = 3'b001;
      order[2] = 3'b100;
      do_cycle(3'b001, 1'b0, 1);
      for (int c = 0; c < 3; c++) begin
         do_cycle(3'b101, 1'b0, 1);
         checks++;
         if (obs_ready !== exp_ready || obs_ready !== order[c]) begin
            failures++;
            $display("FAIL skip_grant c=%0d got=%b exp=%b", c, obs_ready, order[c]);
         end
         checks++;
         if (obs_out !== exp_out) begin
            failures++;
            $display("FAIL skip_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         do_cycle(N'($urandom) | pending, 1'b0, 1);
         checks++;
         if (obs_ready !== exp_ready) begin
            failures++;
            $display("FAIL random_grant c=%0d got=%b exp=%b", c, obs_ready, exp_ready);
         end
         checks++;
         if (obs_out !== exp_out) begin
            failures++;
            $display("FAIL random_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
      end
   endtask

   task automatic test_clear();
      int busy_cnt = 0, wr_cnt = 0, done_cnt = 0;
      bit finished = 0;
      do_cycle(3'b111, 1'b1, 1);
      checks++;
      if (obs_ready !== '0 || obs_ready !== exp_ready) begin
         failures++;
         $display("FAIL clear_entry_ready got=%b exp=%b", obs_ready, exp_ready);
      end
      if (obs_out[1]) busy_cnt++;
      for (int c = 0; c < PIX + 10 && !finished; c++) begin
         do_cycle(3'b111, 1'b0, 1);
         checks++;
         if (obs_ready !== exp_ready) begin
            failures++;
            $display("FAIL clear_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready);
         end
         checks++;
         if (obs_out !== exp_out) begin
            failures++;
            $display("FAIL clear_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
         if (obs_out[1]) busy_cnt++;
         if (obs_out[OW-1]) wr_cnt++;
         if (obs_out[0]) begin
            done_cnt++;
            finished = 1;
            checks++;
            if (fb_addr !== AW'(PIX - 1)) begin
               failures++;
               $display("FAIL clear_last_addr got=%0d exp=%0d", fb_addr, PIX - 1);
            end
         end
      end
      checks++;
      if (!finished || busy_cnt != PIX || wr_cnt != PIX || done_cnt != 1) begin
         failures++;
         $display("FAIL clear_counts busy=%0d writes=%0d done=%0d exp=%0d/%0d/1", busy_cnt, wr_cnt, done_cnt, PIX, PIX);
      end
      do_cycle(3'b111, 1'b0, 1);
      checks++;
      if (obs_ready !== exp_ready || obs_ready === '0) begin
         failures++;
         $display("FAIL clear_resume got=%b exp=%b", obs_ready, exp_ready);
      end
      checks++;
      if (obs_out !== exp_out) begin
         failures++;
         $display("FAIL clear_resume_write got=%h exp=%h", obs_out, exp_out);
      end
   endtask

   task automatic test_clear_held();
      int wr_cnt = 0, done_cnt = 0;
      bit finished = 0;
      for (int c = 0; c < 3; c++) begin
         do_cycle(3'b000, 1'b1, 1);
         if (obs_out[OW-1]) wr_cnt++;
      end
      for (int c = 0; c < PIX + 10 && !finished; c++) begin
         do_cycle(3'b000, 1'b0, 1);
         checks++;
         if (obs_out !== exp_out) begin
            failures++;
            $display("FAIL held_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
         if (obs_out[OW-1]) wr_cnt++;
         if (obs_out[0]) begin
            done_cnt++;
            finished = 1;
         end
      end
      for (int c = 0; c < 5; c++) begin
         do_cycle(3'b000, 1'b0, 1);
         if (obs_out[0]) done_cnt++;
         checks++;
         if (obs_out[1] !== 1'b0 || obs_out !== exp_out) begin
            failures++;
            $display("FAIL held_after c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
      end
      checks++;
      if (!finished || wr_cnt != PIX || done_cnt != 1) begin
         failures++;
         $display("FAIL held_counts writes=%0d done=%0d exp=%0d/1", wr_cnt, done_cnt, PIX);
      end
   endtask

   task automatic test_reset_mid_clear();
      bit hit = 0;
      do_cycle(3'b001, 1'b0, 1);
      do_cycle(3'b000, 1'b1, 1);
      for (int c = 0; c < PIX && !hit; c++) begin
         do_cycle(3'b000, 1'b0, 1);
         checks++;
         if (obs_out !== exp_out) begin
            failures++;
            $display("FAIL midclr_write c=%0d got=%h exp=%h", c, obs_out, exp_out);
         end
         if (fb_we && fb_addr == AW'(1000)) hit = 1;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL midclr_reach got=0 exp=1");
      end
      reset_n     = 1'b0;
      req_valid   = '0;
      clear_start = 1'b0;
      @(posedge clk);
      #1;
      obs_out = {fb_we, fb_addr, fb_wdata, clear_busy, clear_done};
      checks++;
      if (obs_out !== '0) begin
         failures++;
         $display("FAIL midclr_reset got=%h exp=0", obs_out);
      end
      reset_n = 1'b1;
      model_reset();
      do_cycle(3'b110, 1'b0, 1);
      checks++;
      if (obs_ready !== exp_ready || obs_ready !== 3'b010) begin
         failures++;
         $display("FAIL midclr_grant got=%b exp=%b", obs_ready, 3'b010);
      end
      checks++;
      if (obs_out !== exp_out || obs_out[1:0] !== 2'b00) begin
         failures++;
         $display("FAIL midclr_after got=%h exp=%h", obs_out, exp_out);
      end
   endtask

   initial begin
      test_reset();
      test_all_three();
      test_single();
      test_skip();
      test_random();
      test_clear();
      test_clear_held();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single display-framebuffer write port (fb_we/fb_addr/fb_wdata) between NUM_REQ screen painters, one beat per cycle.
- Uses valid/ready handshakes with round-robin fairness.
- Contains a built-in clear engine that fills all PIX_COUNT pixels with CLEAR_COLOUR on request; the engine locks out all painters while it runs.
- Sits between the screen modules and the display framebuffer. The top-level FSM drives clear_start on screen transitions.

Parameters:
- NUM_REQ, 3, number of requester ports (1..8).
- ADDR_W, `DISP_ADDR_WIDTH (17), framebuffer address width.
- PIX_COUNT, 76800, pixels in the 320×240 framebuffer; clear covers addresses 0..PIX_COUNT-1.
- CLEAR_COLOUR, 12'h000, 12-bit RGB colour written by the clear engine.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*32  packed write data; requester i occupies bits [i*32 +: 32].
- req_ready  out  NUM_REQ  grant/accept, combinational, at most one bit high.
- clear_start  in  1  pulse or level; starts a full-screen clear.
- clear_busy  out  1  high while the clear engine owns the port.
- clear_done  out  1  1-cycle pulse when the clear completes.
- fb_we  out  1  framebuffer write enable, registered.
- fb_addr  out  ADDR_W  framebuffer address, registered.
- fb_wdata  out  32  framebuffer data, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (reset_n sampled on posedge clk).
- Reset values:
  - state = ARB, rr_ptr = 0, clear counter = 0.
  - fb_we = 0, fb_addr = 0, fb_wdata = 0.
  - clear_busy = 0, clear_done = 0, req_ready = 0.
- States:
  - ARB: normal arbitration.
  - CLEAR: fill in progress.
- ARB, grant selection:
  - Grantee g is the first index with req_valid set, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g] = 1 combinationally. All other ready bits are 0. If no request is valid, no bit is set.
  - A beat is accepted when req_valid[g] & req_ready[g].
- ARB, accepted beat:
  - Next cycle: fb_we = 1, fb_addr = req_addr[g], fb_wdata = req_wdata[g]. Latency is exactly 1 cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
- ARB, no accepted beat: fb_we <= 0; fb_addr and fb_wdata hold their values; rr_ptr holds.
- Requester obligation: a requester holding valid keeps its addr/data stable until accepted. The arbiter never drops an accepted beat.
- Clear entry: clear_start = 1 in ARB:
  - Forces req_ready = 0 in that same cycle, so clear_start wins over simultaneous requests.
  - Next state is CLEAR, clear counter <= 0, clear_busy <= 1.
  - fb_we <= 0 for that cycle (no accepted beat).
- CLEAR, each cycle:
  - fb_we <= 1, fb_addr <= counter, fb_wdata <= {20'd0, CLEAR_COLOUR}, counter += 1.
  - req_ready = 0 throughout.
- CLEAR exit: the cycle that issues counter == PIX_COUNT-1 also sets:
  - state <= ARB, clear_busy <= 0, clear_done <= 1.
  - clear_done and the final write (addr PIX_COUNT-1) appear on the outputs in the same cycle.
  - Exactly PIX_COUNT writes are issued, with no gaps and no repeats.
- Arbitration resumes on the first cycle with clear_busy = 0. rr_ptr is unchanged by a clear.
- clear_done behaviour: default 0; high for exactly one cycle per completed clear.
- clear_start in CLEAR: ignored, no restart. If it is still high on the first ARB cycle after completion, a new clear starts. The top level must pulse it.
- Reset mid-clear: next cycle returns to reset values. No clear_done is emitted and the partial fill is abandoned.
- Widths: clear counter is ADDR_W bits; PIX_COUNT-1 must be ≤ 2^ADDR_W-1. Data bits above 11 are zero during clear.
- NUM_REQ = 1: degenerates to a pass-through with 1-cycle latency plus the clear engine.

Test Plan:
- Reset, then requester 1 valid with addr 0x00010 and data 0x00000ABC held for 1 cycle -> req_ready = 3'b010 in that cycle; the next cycle fb_we = 1, fb_addr = 0x00010, fb_wdata = 0x00000ABC; the following cycle fb_we = 0.
- All three requesters valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; fb_we high for 6 consecutive cycles, 1 cycle delayed.
- Requesters 0 and 2 valid, rr_ptr = 1 -> requester 2 granted first, then 0, then 2.
- clear_start pulsed together with req_valid = 3'b111 -> req_ready = 0 that cycle; clear_busy high for 76800 cycles; fb_addr steps 0..76799 with fb_wdata = 0x00000000; clear_done pulses together with addr 76799; the pending requester is granted the cycle after.
- clear_start held high for 3 cycles at clear start -> only one clear runs; a single clear_done pulse is produced after 76800 writes.
- reset_n low at clear address 1000 -> next cycle fb_we = 0, clear_busy = 0, no clear_done; after release, a request is granted normally with rr_ptr = 0.
